r2sdf_stage_ctrl: RTL and testbench

//  Sequencer for one radix-2 single-path delay-feedback (R2SDF) FFT stage.
//  - Drives the delay-line enable, the butterfly select and the twiddle ROM address/enable.
//  - Generates output valid/start-of-frame and handles an end-of-stream flush.
//  - Delay-line depth D = 2**LOG2_DEPTH; one instance per FFT stage, sitting beside the stage datapath.

---
 rtl/r2sdf_stage_ctrl.sv | 157 +++++++++++++++
 tb/tb_r2sdf_stage_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/r2sdf_stage_ctrl.sv
// rtl/r2sdf_stage_ctrl.sv - sequencer for one radix-2 single-path delay-feedback FFT stage
// Defining R2SDF_CTRL_FRAMECNT_EN adds the oFrameCnt output-frame counter.
module r2sdf_stage_ctrl #(
   parameter int LOG2_DEPTH = 3,
   parameter int TW_AW      = 4,
   parameter int TW_SHIFT   = 0
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iValid,
   input  logic             iSof,
   input  logic             iFlush,
   output logic             oBufEn,
   output logic             oBfSel,
   output logic             oZeroIn,
   output logic             oTwEn,
   output logic [TW_AW-1:0] oTwAddr,
   output logic             oValid,
   output logic             oSof,
   output logic             oBusy,
   output logic             oErr
`ifdef R2SDF_CTRL_FRAMECNT_EN
   ,
   output logic [15:0]      oFrameCnt
`endif
);

   localparam logic [LOG2_DEPTH:0]   CntOne      = (LOG2_DEPTH+1)'(1);
   localparam logic [LOG2_DEPTH:0]   CntHalf     = {1'b1, {LOG2_DEPTH{1'b0}}};
   localparam logic [LOG2_DEPTH:0]   CntFillLast = {1'b0, {LOG2_DEPTH{1'b1}}};
   localparam logic [LOG2_DEPTH-1:0] FlushOne    = LOG2_DEPTH'(1);
   localparam logic [LOG2_DEPTH-1:0] FlushLast   = {LOG2_DEPTH{1'b1}};

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t                state, stateNext;
   logic [LOG2_DEPTH:0]   cnt, cntNext;
   logic [LOG2_DEPTH-1:0] flushCnt, flushCntNext;

   logic                  accept, tick, strobe, sofRestart;
   logic [LOG2_DEPTH:0]   idx;
   logic [TW_AW-1:0]      localAddr;

   logic                  bufEnNext, bfSelNext, zeroInNext, twEnNext;
   logic [TW_AW-1:0]      twAddrNext;
   logic                  validNext, sofNext, busyNext, errNext;

   // A sample carrying iSof always occupies index 0 of its frame, even when it restarts one.
   assign accept     = ((state == IDLE) && iValid && iSof)
                    || ((state == FILL) && iValid && !iFlush)
                    || ((state == RUN)  && iValid);
   assign tick       = (state == FLUSH);
   assign strobe     = accept || tick;
   assign sofRestart = accept && iSof && (state != IDLE) && (cnt != '0);
   assign idx        = (accept && iSof) ? '0 : cnt;
   assign localAddr  = TW_AW'(idx[LOG2_DEPTH-1:0]) << TW_SHIFT;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state    <= IDLE;
         cnt      <= '0;
         flushCnt <= '0;
         oBufEn   <= 1'b0;
         oBfSel   <= 1'b0;
         oZeroIn  <= 1'b0;
         oTwEn    <= 1'b0;
         oTwAddr  <= '0;
         oValid   <= 1'b0;
         oSof     <= 1'b0;
         oBusy    <= 1'b0;
         oErr     <= 1'b0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         flushCnt <= flushCntNext;
         oBufEn   <= bufEnNext;
         oBfSel   <= bfSelNext;
         oZeroIn  <= zeroInNext;
         oTwEn    <= twEnNext;
         oTwAddr  <= twAddrNext;
         oValid   <= validNext;
         oSof     <= sofNext;
         oBusy    <= busyNext;
         oErr     <= errNext;
      end
   end

   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      flushCntNext = flushCnt;
      if (strobe) begin
         cntNext = (accept && iSof) ? CntOne : cnt + CntOne;
      end
      case (state)
         IDLE: begin
            if (accept) stateNext = FILL;
         end
         FILL: begin
            // Less than half a frame is stored, so a flush here has nothing to drain.
            if (iFlush) begin
               stateNext = IDLE;
               cntNext   = '0;
            end else if (accept && !sofRestart && (cnt == CntFillLast)) begin
               stateNext = RUN;
            end
         end
         RUN: begin
            if (sofRestart) begin
               stateNext = FILL;
            end else if (iFlush) begin
               stateNext    = FLUSH;
               flushCntNext = '0;
            end
         end
         FLUSH: begin
            flushCntNext = flushCnt + FlushOne;
            if (flushCnt == FlushLast) begin
               stateNext = IDLE;
               cntNext   = '0;
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   always_comb begin
      bufEnNext  = strobe;
      bfSelNext  = oBfSel;
      twEnNext   = oTwEn;
      twAddrNext = oTwAddr;
      if (strobe) begin
         bfSelNext  = idx[LOG2_DEPTH];
         twEnNext   = ~idx[LOG2_DEPTH];
         twAddrNext = idx[LOG2_DEPTH] ? '0 : localAddr;
      end
      zeroInNext = tick;
      validNext  = tick || ((state == RUN) && accept && !sofRestart);
      sofNext    = (state == RUN) && accept && !sofRestart && (cnt == CntHalf);
      errNext    = sofRestart;
      busyNext   = (stateNext != IDLE);
   end

`ifdef R2SDF_CTRL_FRAMECNT_EN
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oFrameCnt <= '0;
      end else if (sofNext) begin
         oFrameCnt <= oFrameCnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_r2sdf_stage_ctrl.sv
// tb/tb_r2sdf_stage_ctrl.sv - self-checking bench for r2sdf_stage_ctrl
// Frame-position reference model; also checks oFrameCnt when R2SDF_CTRL_FRAMECNT_EN is defined.
module tb_r2sdf_stage_ctrl;

   localparam int LD   = 3;
   localparam int D    = 1 << LD;
   localparam int TWAW = 4;
   localparam int SH   = 1;

   logic            iClk = 1'b0;
   logic            iRst, iValid, iSof, iFlush;
   logic            oBufEn, oBfSel, oZeroIn, oTwEn, oValid, oSof, oBusy, oErr;
   logic [TWAW-1:0] oTwAddr;
`ifdef R2SDF_CTRL_FRAMECNT_EN
   logic [15:0]     oFrameCnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: position within the 2D frame, samples stored since (re)start, drain left.
   bit  inFrame;
   int  pos, stored, drainLeft, sofSeen, flushValid;
   logic eBufEn, eBfSel, eZero, eTwEn, eValid, eSof, eBusy, eErr;
   logic [TWAW-1:0] eTwAddr;

   r2sdf_stage_ctrl #(.LOG2_DEPTH(LD), .TW_AW(TWAW), .TW_SHIFT(SH)) dut (
      .iClk(iClk), .iRst(iRst), .iValid(iValid), .iSof(iSof), .iFlush(iFlush),
      .oBufEn(oBufEn), .oBfSel(oBfSel), .oZeroIn(oZeroIn), .oTwEn(oTwEn),
      .oTwAddr(oTwAddr), .oValid(oValid), .oSof(oSof), .oBusy(oBusy), .oErr(oErr)
`ifdef R2SDF_CTRL_FRAMECNT_EN
      , .oFrameCnt(oFrameCnt)
`endif
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic emit(input int i);
      eBufEn  = 1'b1;
      eBfSel  = (i >= D);
      eTwEn   = (i < D);
      eTwAddr = (i < D) ? TWAW'((i << SH) % (1 << TWAW)) : '0;
   endtask

   task automatic modelStep(input logic r, input logic v, input logic s, input logic f);
      bit run, errHit;
      eBufEn = 1'b0; eValid = 1'b0; eSof = 1'b0; eZero = 1'b0; eErr = 1'b0;
      if (r) begin
         inFrame = 0; pos = 0; stored = 0; drainLeft = 0; sofSeen = 0;
         eBfSel = 1'b0; eTwEn = 1'b0; eTwAddr = '0;
      end else if (drainLeft > 0) begin
         emit(pos);
         eZero = 1'b1; eValid = 1'b1;
         pos = (pos + 1) % (2 * D);
         drainLeft--;
         if (drainLeft == 0) begin
            inFrame = 0; pos = 0; stored = 0;
         end
      end else if (!inFrame) begin
         if (v && s) begin
            emit(0);
            inFrame = 1; pos = 1; stored = 1;
         end
      end else begin
         run = (stored >= D);
         if (!run && f) begin
            inFrame = 0; pos = 0; stored = 0;
         end else begin
            errHit = 0;
            if (v) begin
               if (s && pos != 0) begin
                  emit(0);
                  eErr = 1'b1; errHit = 1;
                  pos = 1; stored = 1;
               end else begin
                  emit(pos);
                  if (run) begin
                     eValid = 1'b1;
                     eSof   = (pos == D);
                  end
                  if (stored < D) stored++;
                  pos = (pos + 1) % (2 * D);
               end
            end
            if (run && f && !errHit) drainLeft = D;
         end
      end
      if (eSof) sofSeen = (sofSeen + 1) % 65536;
      eBusy = inFrame;
   endtask

   task automatic cycle(input logic r, input logic v, input logic s, input logic f);
      iRst = r; iValid = v; iSof = s; iFlush = f;
      modelStep(r, v, s, f);
      @(posedge iClk);
      #1;
      chk("oBufEn",  16'(oBufEn),  16'(eBufEn));
      chk("oValid",  16'(oValid),  16'(eValid));
      chk("oSof",    16'(oSof),    16'(eSof));
      chk("oZeroIn", 16'(oZeroIn), 16'(eZero));
      chk("oErr",    16'(oErr),    16'(eErr));
      chk("oBusy",   16'(oBusy),   16'(eBusy));
      chk("oBfSel",  16'(oBfSel),  16'(eBfSel));
      chk("oTwAddr", 16'(oTwAddr), 16'(eTwAddr));
      if (eBufEn) chk("oTwEn", 16'(oTwEn), 16'(eTwEn));
`ifdef R2SDF_CTRL_FRAMECNT_EN
      chk("oFrameCnt", oFrameCnt, 16'(sofSeen));
`endif
      if (oValid === 1'b1 && oZeroIn === 1'b1) flushValid++;
   endtask

   initial begin
      iRst = 1'b1; iValid = 1'b0; iSof = 1'b0; iFlush = 1'b0;
      inFrame = 0; pos = 0; stored = 0; drainLeft = 0; sofSeen = 0; flushValid = 0;

      repeat (3) cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));

      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1);

      for (int fr = 0; fr < 2; fr++)
         for (int k = 0; k < 2 * D; k++) cycle(0, 1, k == 0, 0);

      for (int k = 0; k < 2 * D; k++) begin
         cycle(0, 1, k == 0, 0);
         cycle(0, 0, 0, 0);
         cycle(0, 0, 0, 0);
      end

      for (int k = 0; k < 4; k++) cycle(0, 1, k == 0, 0);
      for (int k = 0; k < 2 * D + 3; k++) cycle(0, 1, k == 0, 0);

      flushValid = 0;
      cycle(0, 1, 0, 1);
      repeat (D + 3) cycle(0, 1'($urandom), 0, 1'($urandom));
      chk("flushValidCount", 16'(flushValid), 16'(D));

      cycle(0, 1, 1, 0);
      repeat (3) cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1);
      repeat (2) cycle(0, 1, 0, 0);

      for (int k = 0; k < 10; k++) cycle(0, 1, k == 0, 0);
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);

      for (int k = 0; k < 600; k++) begin
         cycle(($urandom % 250) == 0, ($urandom % 100) < 70,
               ($urandom % 100) < 4, ($urandom % 100) < 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
